// File: rtl/rf_motion_controller_pkg.sv
// Shared types and constants for the RF motion controller.
// Channel FSM state encoding and RF line bit positions.
package rf_motion_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_REVERSE = 3'd2,
    ST_LIMIT   = 3'd3,
    ST_BACKOFF = 3'd4
  } ch_state_t;

  localparam int RF_DIR0 = 0;
  localparam int RF_DIR1 = 1;
  localparam int RF_RUN0 = 2;
  localparam int RF_RUN1 = 3;

  function automatic logic drives(ch_state_t s);
    return (s == ST_RUN) || (s == ST_BACKOFF);
  endfunction

endpackage

// File: rtl/rf_channel_fsm.sv
// Per-motor interlock: run/stop, reversal dead-time,
// limit stop and back-off in the opposite direction only.
module rf_channel_fsm
  import rf_motion_controller_pkg::*;
#(
  parameter int unsigned REVERSE_GAP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_press,
  input  logic dir_press,
  input  logic limit,
  output logic direction,
  output logic enable,
  output logic at_limit
);

  localparam int unsigned GW = $clog2(REVERSE_GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(REVERSE_GAP_CYCLES - 1);

  ch_state_t     state;
  ch_state_t     state_nxt;
  logic          dir_nxt;
  logic          trip_dir;
  logic          trip_nxt;
  logic [GW-1:0] gap;
  logic [GW-1:0] gap_nxt;
  logic          dir_tgl;

  assign dir_tgl = direction ^ dir_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      direction <= 1'b0;
      trip_dir  <= 1'b0;
      gap       <= '0;
      enable    <= 1'b0;
      at_limit  <= 1'b0;
    end else begin
      state     <= state_nxt;
      direction <= dir_nxt;
      trip_dir  <= trip_nxt;
      gap       <= gap_nxt;
      enable    <= drives(state_nxt);
      at_limit  <= (state_nxt == ST_LIMIT);
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = direction;
    trip_nxt  = trip_dir;
    gap_nxt   = gap;
    unique case (state)
      ST_IDLE: begin
        dir_nxt = dir_tgl;
        if (run_press) begin
          if (limit) begin
            state_nxt = ST_LIMIT;
            trip_nxt  = dir_tgl;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (limit) begin
          state_nxt = ST_LIMIT;
          trip_nxt  = direction;
        end else if (run_press) begin
          state_nxt = ST_IDLE;
          dir_nxt   = dir_tgl;
        end else if (dir_press) begin
          state_nxt = ST_REVERSE;
          dir_nxt   = dir_tgl;
          gap_nxt   = '0;
        end
      end
      ST_REVERSE: begin
        if (limit) begin
          state_nxt = ST_LIMIT;
          trip_nxt  = direction;
          gap_nxt   = '0;
        end else if (run_press) begin
          state_nxt = ST_IDLE;
          dir_nxt   = dir_tgl;
          gap_nxt   = '0;
        end else if (dir_press) begin
          dir_nxt = dir_tgl;
          gap_nxt = '0;
        end else if (gap >= GAP_LAST) begin
          state_nxt = ST_RUN;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap + 1'b1;
        end
      end
      ST_LIMIT: begin
        dir_nxt = dir_tgl;
        if (run_press) begin
          if (dir_tgl != trip_dir) begin
            state_nxt = ST_BACKOFF;
          end
        end else if (!dir_press && !limit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BACKOFF: begin
        // Limit stays asserted while backing off.
        if (run_press) begin
          state_nxt = ST_IDLE;
          dir_nxt   = dir_tgl;
        end else if (dir_press) begin
          state_nxt = ST_LIMIT;
          dir_nxt   = dir_tgl;
        end else if (!limit) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/rf_debounce.sv
// One RF line: 2-flop synchroniser, stability counter,
// and a single-cycle pulse on each accepted rising level.
module rf_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  // The level flips on the cycle the count reaches the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
        press <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_motion_controller.sv
// RF command front end for two stepper channels:
// debounced RF presses and synced limits into two interlock FSMs.
module rf_motion_controller
  import rf_motion_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = 1_000_000,
  parameter int unsigned REVERSE_GAP_CYCLES = 25_000_000,
  parameter logic        LIMIT_ACTIVE       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rf_input,
  input  logic [1:0] limit_switches,
  output logic [1:0] direction,
  output logic [1:0] enable,
  output logic [1:0] at_limit
);

  logic [3:0] press;
  logic [1:0] lim_s1;
  logic [1:0] lim_s2;
  logic [1:0] lim_hit;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    rf_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (rf_input[i]),
      .press(press[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lim_s1 <= 2'b00;
      lim_s2 <= 2'b00;
    end else begin
      lim_s1 <= limit_switches;
      lim_s2 <= lim_s1;
    end
  end

  assign lim_hit = ~(lim_s2 ^ {2{LIMIT_ACTIVE}});

  rf_channel_fsm #(
    .REVERSE_GAP_CYCLES(REVERSE_GAP_CYCLES)
  ) u_ch0 (
    .clk      (clk),
    .rst      (rst),
    .run_press(press[RF_RUN0]),
    .dir_press(press[RF_DIR0]),
    .limit    (lim_hit[0]),
    .direction(direction[0]),
    .enable   (enable[0]),
    .at_limit (at_limit[0])
  );

  rf_channel_fsm #(
    .REVERSE_GAP_CYCLES(REVERSE_GAP_CYCLES)
  ) u_ch1 (
    .clk      (clk),
    .rst      (rst),
    .run_press(press[RF_RUN1]),
    .dir_press(press[RF_DIR1]),
    .limit    (lim_hit[1]),
    .direction(direction[1]),
    .enable   (enable[1]),
    .at_limit (at_limit[1])
  );

endmodule

// File: tb/tb_rf_motion_controller.sv
// Directed bench for rf_motion_controller, short debounce/gap.
// Inputs driven and outputs sampled on the falling edge.
module tb_rf_motion_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] rf_input = 4'hF;
  logic [1:0] limit_switches = 2'b11;
  logic [1:0] direction;
  logic [1:0] enable;
  logic [1:0] at_limit;
  logic [5:0] outs;

  int n_vec  = 0;
  int n_miss = 0;

  assign outs = {direction, enable, at_limit};

  always #5 clk = ~clk;

  rf_motion_controller #(
    .DEBOUNCE_CYCLES   (4),
    .REVERSE_GAP_CYCLES(8),
    .LIMIT_ACTIVE      (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rf_input      (rf_input),
    .limit_switches(limit_switches),
    .direction     (direction),
    .enable        (enable),
    .at_limit      (at_limit)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise lines; returns on the edge the FSM acts.
  task automatic press_on(input logic [3:0] m);
    rf_input = rf_input | m;
    tick(7);
  endtask

  task automatic press_off(input logic [3:0] m);
    tick(1);
    rf_input = rf_input & ~m;
    tick(8);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_hold", 8'(outs), 8'h00);
    end
    rf_input       = 4'h0;
    limit_switches = 2'b00;
    tick(2);
    rst = 1'b1;
    tick(4);
    check("rst_out", 8'(outs), 8'h00);

    // glitch then clean run press on ch0
    rf_input[2] = 1'b1;
    tick(3);
    rf_input[2] = 1'b0;
    tick(6);
    check("glitch", 8'(enable), 8'h0);
    rf_input[2] = 1'b1;
    tick(6);
    check("run_lat6", 8'(enable), 8'h0);
    tick(1);
    check("run_lat7", 8'(enable), 8'h1);
    tick(3);
    rf_input[2] = 1'b0;
    tick(8);

    // reversal dead-time on ch0
    rf_input[0] = 1'b1;
    tick(6);
    check("rev_pre", 8'(direction[0]), 8'h0);
    tick(1);
    check("rev_start", 8'({direction[0], enable[0]}), 8'h2);
    rf_input[0] = 1'b0;
    tick(7);
    check("rev_hold", 8'(enable[0]), 8'h0);
    tick(1);
    check("rev_end", 8'(enable[0]), 8'h1);
    tick(4);

    // ch1 run, then limit
    press_on(4'b1000);
    check("ch1_run", 8'(outs), 8'b01_11_00);
    press_off(4'b1000);
    limit_switches[1] = 1'b1;
    tick(2);
    check("lim_lat2", 8'(enable[1]), 8'h1);
    tick(1);
    check("lim_trip", 8'({enable[1], at_limit[1]}), 8'h1);
    check("ch0_indep", 8'(enable[0]), 8'h1);
    press_on(4'b1000);
    check("lim_run_ign", 8'({enable[1], at_limit[1]}), 8'h1);
    press_off(4'b1000);
    press_on(4'b0010);
    check("lim_dir", 8'({direction[1], at_limit[1]}), 8'h3);
    press_off(4'b0010);
    press_on(4'b1000);
    check("backoff", 8'({enable[1], at_limit[1]}), 8'h2);
    press_off(4'b1000);
    limit_switches[1] = 1'b0;
    tick(3);
    check("lim_rel", 8'({enable[1], at_limit[1]}), 8'h2);
    tick(2);
    rf_input[1] = 1'b1;
    tick(7);
    check("ch1_rev",
          8'({enable[1], at_limit[1], direction[1]}), 8'h0);
    tick(1);
    rf_input[1] = 1'b0;
    tick(8);
    check("ch1_rev_end", 8'(enable[1]), 8'h1);

    // simultaneous run+dir: RUN -> IDLE, then IDLE -> RUN
    press_on(4'b0101);
    check("sim_run", 8'({direction[0], enable[0]}), 8'h0);
    press_off(4'b0101);
    check("sim_idle", 8'(enable), 8'h2);
    rf_input = rf_input | 4'b0101;
    tick(6);
    check("sim_pre", 8'({direction[0], enable[0]}), 8'h0);
    tick(1);
    check("sim_go", 8'({direction[0], enable[0]}), 8'h3);
    press_off(4'b0101);

    // async reset mid-reverse on both channels
    press_on(4'b0011);
    check("both_rev", 8'(outs), 8'b10_00_00);
    rf_input = 4'h0;
    tick(2);
    #2 rst = 1'b0;
    #1 check("async_rst", 8'(outs), 8'h00);
    tick(2);
    rst = 1'b1;
    tick(12);
    check("no_auto_run", 8'(outs), 8'h00);
    press_on(4'b0100);
    check("fresh_run", 8'(enable), 8'h1);
    press_off(4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
